// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the L1 block-memory arbiter.
// Holds the FSM state encoding and the owner codes.
package mem_arb_pkg;

  localparam int BLOCK_W_DEF = 256;
  localparam int STREAK_W    = 4;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_I_RD    = 3'd1,
    ST_D_RD    = 3'd2,
    ST_D_WR    = 3'd3,
    ST_RELEASE = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_I    = 2'd1,
    OWN_DR   = 2'd2,
    OWN_DW   = 2'd3
  } owner_t;

endpackage

// File: rtl/l1_mem_arbiter_if.sv
// Bundle of cache-side, memory-side and status signals around the arbiter.
// slave = arbiter view, master = caches plus memory view.
interface l1_mem_arbiter_if
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int BLOCK_W = BLOCK_W_DEF
);
  logic               i_req;
  logic [ADDR_W-1:0]  i_addr;
  logic [BLOCK_W-1:0] i_data;
  logic               i_valid;
  logic               d_read_req;
  logic               d_write_req;
  logic [ADDR_W-1:0]  d_addr;
  logic [BLOCK_W-1:0] d_write_data;
  logic [BLOCK_W-1:0] d_read_data;
  logic               d_read_valid;
  logic               d_write_valid;
  logic [ADDR_W-1:0]  mem_addr;
  logic               mem_blk_read;
  logic               mem_blk_write;
  logic [BLOCK_W-1:0] mem_write_data;
  logic [BLOCK_W-1:0] mem_read_data;
  logic               mem_read_valid;
  logic               mem_write_valid;
  logic               busy;
  logic [1:0]         owner;

  modport slave (
    input  i_req, i_addr, d_read_req, d_write_req, d_addr, d_write_data,
           mem_read_data, mem_read_valid, mem_write_valid,
    output i_data, i_valid, d_read_data, d_read_valid, d_write_valid,
           mem_addr, mem_blk_read, mem_blk_write, mem_write_data, busy, owner
  );

  modport master (
    output i_req, i_addr, d_read_req, d_write_req, d_addr, d_write_data,
           mem_read_data, mem_read_valid, mem_write_valid,
    input  i_data, i_valid, d_read_data, d_read_valid, d_write_valid,
           mem_addr, mem_blk_read, mem_blk_write, mem_write_data, busy, owner
  );
endinterface

// File: rtl/l1_mem_arb_pick.sv
// Combinational grant selector: write-back, then D read, then I read,
// except that a waiting I request wins once the D streak hits its limit.
module l1_mem_arb_pick
  import mem_arb_pkg::*;
#(
  parameter int MAX_D_STREAK = 4
) (
  input  logic                iReq,
  input  logic                dReadReq,
  input  logic                dWriteReq,
  input  logic [STREAK_W-1:0] dStreak,
  output owner_t              grant
);

  always_comb begin
    grant = OWN_NONE;
    if (iReq && (dStreak == STREAK_W'(MAX_D_STREAK))) grant = OWN_I;
    else if (dWriteReq)                                grant = OWN_DW;
    else if (dReadReq)                                 grant = OWN_DR;
    else if (iReq)                                     grant = OWN_I;
  end

endmodule

// File: rtl/l1_mem_arbiter.sv
// Shares one block-memory port between the L1 I- and D-caches, with fixed
// D priority bounded by a starvation limit and a one-cycle RELEASE per grant.
module l1_mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W       = 32,
  parameter int BLOCK_W      = BLOCK_W_DEF,
  parameter int MAX_D_STREAK = 4
) (
  input logic             CLK,
  input logic             RESET,
  l1_mem_arbiter_if.slave bus
);

  state_t              state, stateNext;
  owner_t              grant, ownerQ;
  logic [STREAK_W-1:0] dStreak;
  logic [ADDR_W-1:0]   memAddr;
  logic [BLOCK_W-1:0]  memWriteData, iData, dReadData;

  l1_mem_arb_pick #(.MAX_D_STREAK(MAX_D_STREAK)) uPick (
    .iReq      (bus.i_req),
    .dReadReq  (bus.d_read_req),
    .dWriteReq (bus.d_write_req),
    .dStreak   (dStreak),
    .grant     (grant)
  );

  always_ff @(posedge CLK) begin
    if (RESET) state <= ST_IDLE;
    else       state <= stateNext;
  end

  // Responses arriving in a state that does not expect them are dropped.
  always_comb begin
    stateNext = state;
    unique case (state)
      ST_IDLE: begin
        unique case (grant)
          OWN_I:   stateNext = ST_I_RD;
          OWN_DR:  stateNext = ST_D_RD;
          OWN_DW:  stateNext = ST_D_WR;
          default: stateNext = ST_IDLE;
        endcase
      end
      ST_I_RD, ST_D_RD: if (bus.mem_read_valid)  stateNext = ST_RELEASE;
      ST_D_WR:          if (bus.mem_write_valid) stateNext = ST_RELEASE;
      ST_RELEASE:       stateNext = ST_IDLE;
      default:          stateNext = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      ownerQ       <= OWN_NONE;
      dStreak      <= '0;
      memAddr      <= '0;
      memWriteData <= '0;
      iData        <= '0;
      dReadData    <= '0;
    end else begin
      if (state == ST_IDLE && grant != OWN_NONE) begin
        ownerQ  <= grant;
        memAddr <= (grant == OWN_I) ? bus.i_addr : bus.d_addr;
        if (grant == OWN_DW) memWriteData <= bus.d_write_data;
        // Streak counts only D grants that made a pending I request wait.
        if (grant == OWN_I || !bus.i_req)
          dStreak <= '0;
        else if (dStreak != STREAK_W'(MAX_D_STREAK))
          dStreak <= dStreak + 1'b1;
      end
      if (state == ST_RELEASE) ownerQ <= OWN_NONE;
      if (state == ST_I_RD && bus.mem_read_valid) iData     <= bus.mem_read_data;
      if (state == ST_D_RD && bus.mem_read_valid) dReadData <= bus.mem_read_data;
    end
  end

  assign bus.mem_addr       = memAddr;
  assign bus.mem_write_data = memWriteData;
  assign bus.mem_blk_read   = (state == ST_I_RD) || (state == ST_D_RD);
  assign bus.mem_blk_write  = (state == ST_D_WR);
  assign bus.i_data         = iData;
  assign bus.d_read_data    = dReadData;
  assign bus.i_valid        = (state == ST_RELEASE) && (ownerQ == OWN_I);
  assign bus.d_read_valid   = (state == ST_RELEASE) && (ownerQ == OWN_DR);
  assign bus.d_write_valid  = (state == ST_RELEASE) && (ownerQ == OWN_DW);
  assign bus.busy           = (state != ST_IDLE);
  assign bus.owner          = ownerQ;

endmodule

// File: tb/tb_l1_mem_arbiter.sv
// Directed bench for l1_mem_arbiter: inputs change and outputs are sampled
// 1 ns after each rising edge.
module tb_l1_mem_arbiter;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  l1_mem_arbiter_if #(.ADDR_W(32), .BLOCK_W(256)) bus ();

  l1_mem_arbiter #(.ADDR_W(32), .BLOCK_W(256), .MAX_D_STREAK(4)) dut (
    .CLK   (clk),
    .RESET (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Exclusivity of request strobes and response pulses, checked every cycle.
  always @(negedge clk) begin
    if (!rst) begin
      checks++;
      assert (!(bus.mem_blk_read && bus.mem_blk_write) &&
              ({2'b0, bus.i_valid} + {2'b0, bus.d_read_valid} + {2'b0, bus.d_write_valid} <= 3'd1))
      else begin
        failures++;
        $error("FAIL exclusive observed=rd%0b wr%0b iv%0b drv%0b dwv%0b required=at-most-one",
               bus.mem_blk_read, bus.mem_blk_write, bus.i_valid, bus.d_read_valid, bus.d_write_valid);
      end
    end
  end

  logic [255:0] blkA5, blkWb, blkRd, blkC3, blkW2;
  logic [1:0]   expOwn;

  initial begin
    checks   = 0;
    failures = 0;
    blkA5 = {32{8'hA5}};
    blkWb = {8{32'hDEADBEEF}};
    blkRd = {16{16'h1234}};
    blkC3 = {32{8'hC3}};
    blkW2 = {8{32'h0BADF00D}};
    rst = 1'b1;
    bus.i_req = 0; bus.i_addr = '0;
    bus.d_read_req = 0; bus.d_write_req = 0; bus.d_addr = '0; bus.d_write_data = '0;
    bus.mem_read_data = '0; bus.mem_read_valid = 0; bus.mem_write_valid = 0;
    tick(); tick();

    // Reset values
    chk("rst_busy", bus.busy, 0);
    chk("rst_owner", bus.owner, 0);
    chk("rst_blk_read", bus.mem_blk_read, 0);
    chk("rst_blk_write", bus.mem_blk_write, 0);
    chk("rst_mem_addr", bus.mem_addr, 0);
    chk("rst_mem_wdata", bus.mem_write_data, 0);
    chk("rst_i_data", bus.i_data, 0);
    chk("rst_d_rdata", bus.d_read_data, 0);
    chk("rst_valids", {bus.i_valid, bus.d_read_valid, bus.d_write_valid}, 0);
    rst = 1'b0;
    tick();

    // I-only read, memory answers two cycles after the request
    bus.i_req = 1; bus.i_addr = 32'h0040_0020;
    tick();
    chk("i_blk_read", bus.mem_blk_read, 1);
    chk("i_mem_addr", bus.mem_addr, 32'h0040_0020);
    chk("i_owner", bus.owner, 1);
    chk("i_busy", bus.busy, 1);
    tick();
    chk("i_wait_blk_read", bus.mem_blk_read, 1);
    chk("i_wait_no_valid", bus.i_valid, 0);
    bus.mem_read_valid = 1; bus.mem_read_data = blkA5;
    tick();
    chk("i_valid", bus.i_valid, 1);
    chk("i_data", bus.i_data, blkA5);
    chk("i_rel_blk_read", bus.mem_blk_read, 0);
    chk("i_d_side_quiet", {bus.d_read_valid, bus.d_write_valid}, 0);
    chk("i_d_rdata_zero", bus.d_read_data, 0);
    bus.mem_read_valid = 0; bus.i_req = 0;
    tick();
    chk("i_idle_busy", bus.busy, 0);
    chk("i_idle_owner", bus.owner, 0);
    chk("i_valid_pulse_end", bus.i_valid, 0);
    chk("i_data_held", bus.i_data, blkA5);

    // Write-back precedes refill when both arrive together
    bus.d_write_req = 1; bus.d_read_req = 1;
    bus.d_addr = 32'h1000_0040; bus.d_write_data = blkWb;
    tick();
    chk("wb_owner", bus.owner, 3);
    chk("wb_blk_write", bus.mem_blk_write, 1);
    chk("wb_blk_read", bus.mem_blk_read, 0);
    chk("wb_mem_addr", bus.mem_addr, 32'h1000_0040);
    chk("wb_mem_wdata", bus.mem_write_data, blkWb);
    bus.mem_write_valid = 1;
    tick();
    chk("wb_valid", bus.d_write_valid, 1);
    chk("wb_rel_strobes", {bus.mem_blk_read, bus.mem_blk_write}, 0);
    bus.mem_write_valid = 0; bus.d_write_req = 0;
    tick();
    chk("wb_idle", bus.busy, 0);
    chk("wb_valid_end", bus.d_write_valid, 0);
    tick();
    chk("rd_owner", bus.owner, 2);
    chk("rd_blk_read", bus.mem_blk_read, 1);
    chk("rd_blk_write", bus.mem_blk_write, 0);
    bus.mem_read_valid = 1; bus.mem_read_data = blkRd;
    tick();
    chk("rd_valid", bus.d_read_valid, 1);
    chk("rd_data", bus.d_read_data, blkRd);
    chk("rd_no_i_valid", bus.i_valid, 0);
    chk("rd_i_data_held", bus.i_data, blkA5);
    bus.mem_read_valid = 0; bus.d_read_req = 0;
    tick();
    chk("rd_idle", bus.busy, 0);

    // Starvation: four D grants while I waits, then I, then D again
    bus.i_req = 1; bus.d_read_req = 1; bus.mem_read_valid = 1; bus.mem_read_data = blkC3;
    for (int n = 0; n < 6; n++) begin
      expOwn = (n == 4) ? 2'd1 : 2'd2;
      tick();
      chk($sformatf("starve_owner_%0d", n), bus.owner, expOwn);
      chk($sformatf("starve_blk_read_%0d", n), bus.mem_blk_read, 1);
      tick();
      chk($sformatf("starve_ivalid_%0d", n), bus.i_valid, expOwn == 2'd1);
      chk($sformatf("starve_dvalid_%0d", n), bus.d_read_valid, expOwn == 2'd2);
      if (n == 5) begin
        bus.i_req = 0; bus.d_read_req = 0; bus.mem_read_valid = 0;
      end
      tick();
      chk($sformatf("starve_idle_%0d", n), bus.busy, 0);
    end
    chk("starve_i_data", bus.i_data, blkC3);

    // Requester withdraws after grant; transaction still completes once
    bus.d_read_req = 1; bus.d_addr = 32'h2000_0080;
    tick();
    bus.d_read_req = 0;
    chk("wd_owner", bus.owner, 2);
    chk("wd_mem_addr", bus.mem_addr, 32'h2000_0080);
    tick();
    chk("wd_still_busy", bus.busy, 1);
    chk("wd_still_blk_read", bus.mem_blk_read, 1);
    bus.mem_read_valid = 1; bus.mem_read_data = blkW2;
    tick();
    chk("wd_valid", bus.d_read_valid, 1);
    chk("wd_data", bus.d_read_data, blkW2);
    bus.mem_read_valid = 0;
    tick();
    chk("wd_valid_end", bus.d_read_valid, 0);
    tick();
    chk("wd_no_regrant", bus.busy, 0);
    chk("wd_no_blk_read", bus.mem_blk_read, 0);

    // Reset during an I read abandons it
    bus.i_req = 1; bus.i_addr = 32'h0050_0000;
    tick();
    chk("rr_busy_before", bus.busy, 1);
    rst = 1; bus.i_req = 0;
    tick();
    chk("rr_busy", bus.busy, 0);
    chk("rr_owner", bus.owner, 0);
    chk("rr_blk_read", bus.mem_blk_read, 0);
    chk("rr_mem_addr", bus.mem_addr, 0);
    chk("rr_i_data", bus.i_data, 0);
    rst = 0; bus.mem_read_valid = 1; bus.mem_read_data = blkA5;
    tick();
    chk("rr_late_no_ivalid", bus.i_valid, 0);
    chk("rr_late_busy", bus.busy, 0);
    tick();
    chk("rr_late_no_ivalid2", bus.i_valid, 0);
    chk("rr_late_i_data", bus.i_data, 0);
    bus.mem_read_valid = 0;

    // Spurious responses: read-valid in IDLE, write-valid during an I read
    tick();
    chk("sp_idle_busy", bus.busy, 0);
    bus.i_req = 1; bus.i_addr = 32'h0060_0040;
    tick();
    bus.mem_write_valid = 1;
    tick();
    chk("sp_owner", bus.owner, 1);
    chk("sp_blk_read", bus.mem_blk_read, 1);
    chk("sp_no_pulse", {bus.i_valid, bus.d_read_valid, bus.d_write_valid}, 0);
    bus.mem_write_valid = 0; bus.mem_read_valid = 1; bus.mem_read_data = blkRd;
    tick();
    chk("sp_i_valid", bus.i_valid, 1);
    chk("sp_i_data", bus.i_data, blkRd);
    bus.mem_read_valid = 0; bus.i_req = 0;
    tick();
    chk("sp_idle_end", bus.busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/l1_mem_arbiter.md
Name: l1_mem_arbiter

Overview:
- Shares the single 256-bit block-memory port between the L1 instruction cache (block reads only) and the L1 data cache (block reads and dirty write-backs).
- Sits between both L1 caches and the top-level memory ports: mem-side signals drive the top-level block address, block read/write requests and write data.
- Serialises requests with a fixed D-side priority, bounded by a starvation limit, and registers responses back to the owning cache.

Parameters:
- ADDR_W, 32, address width.
- BLOCK_W, 256, cache block width in bits.
- MAX_D_STREAK, 4, consecutive D-cache grants allowed while an I-cache request waits; then I is forced. Range 1..15.

Ports:
- CLK  in  1  clock.
- RESET  in  1  synchronous, active-high reset.
- i_req  in  1  I-cache block read request; level, held until i_valid.
- i_addr  in  ADDR_W  I-cache block address.
- i_data  out  BLOCK_W  block returned to I-cache.
- i_valid  out  1  one-cycle pulse; i_data valid.
- d_read_req  in  1  D-cache block read request; level.
- d_write_req  in  1  D-cache write-back request; level.
- d_addr  in  ADDR_W  D-cache block address (read or write-back).
- d_write_data  in  BLOCK_W  write-back block.
- d_read_data  out  BLOCK_W  block returned to D-cache.
- d_read_valid  out  1  one-cycle pulse; d_read_data valid.
- d_write_valid  out  1  one-cycle pulse; write-back accepted.
- mem_addr  out  ADDR_W  latched address of the current transaction.
- mem_blk_read  out  1  block read request, held for the whole transaction.
- mem_blk_write  out  1  block write request, held for the whole transaction.
- mem_write_data  out  BLOCK_W  latched write-back block.
- mem_read_data  in  BLOCK_W  block from memory.
- mem_read_valid  in  1  memory read complete.
- mem_write_valid  in  1  memory write complete.
- busy  out  1  state is not IDLE.
- owner  out  2  current owner: 0 none, 1 I-read, 2 D-read, 3 D-write.

Behaviour:
- Reset: state IDLE, d_streak 0. All valid, request and busy outputs 0; owner 0; mem_addr, mem_write_data, i_data and d_read_data 0.
- Reset asserted mid-transaction: the transaction is abandoned; the next cycle shows reset values and no response pulse is issued.
- States: IDLE, I_RD, D_RD, D_WR, RELEASE.
- IDLE pick order:
  - d_write_req goes first, so write-back always precedes a refill.
  - then d_read_req.
  - then i_req.
  - Exception: if i_req=1 and d_streak==MAX_D_STREAK, I wins over both D requests.
- On a grant in cycle t: latch address (and d_write_data for D_WR) into mem_addr/mem_write_data. The matching mem_blk_* goes high from t+1.
- d_streak update:
  - Increments (saturating) on a D grant while i_req=1.
  - Clears on an I grant, or on a D grant with i_req=0.
- I_RD/D_RD: hold mem_blk_read until mem_read_valid (cycle k).
  - At the edge ending k: capture mem_read_data into i_data or d_read_data and go to RELEASE.
  - In cycle k+1: pulse i_valid or d_read_valid; mem_blk_read is 0.
- D_WR: hold mem_blk_write until mem_write_valid (cycle k); pulse d_write_valid in k+1 (RELEASE).
- RELEASE lasts exactly one cycle. Requests are ignored there so the requester can drop its req; IDLE again at k+2.
- Minimum transaction period: grant + 1 memory cycle + RELEASE = 3 cycles.
- A mem_read_valid or mem_write_valid that does not match the current state (including in IDLE) is ignored.
- A requester dropping its req mid-transaction does not abort: the transaction completes and the response still pulses.
- i_data and d_read_data hold their last captured value between pulses.
- At most one of i_valid, d_read_valid, d_write_valid is high in any cycle. mem_blk_read and mem_blk_write are never both high.

Decomposition:
- Shared package mem_arb_pkg:
  - state encoding.
  - owner codes (OWN_NONE=0, OWN_I=1, OWN_DR=2, OWN_DW=3).
  - BLOCK_W default.
- One sub-module, l1_mem_arb_pick: combinational priority/starvation selector taking the request bits and d_streak, returning the grant code. The FSM, latches and counter stay in l1_mem_arbiter.

Test Plan:
- I-only: i_req=1, i_addr=0x0040_0020, memory answers 2 cycles after request; block 0xA5..A5 → mem_blk_read high with mem_addr=0x0040_0020; i_valid one cycle with i_data=0xA5..A5; d-side outputs stay 0.
- Write-before-read: d_write_req=1 and d_read_req=1 together, d_addr=0x1000_0040 → D_WR completes with d_write_valid, then D_RD with d_read_valid; mem_blk_write and mem_blk_read never overlap.
- Starvation, MAX_D_STREAK=4: i_req held while D requests back-to-back → exactly 4 D grants, then an I grant; d_streak returns to 0.
- Withdrawal: d_read_req dropped in the cycle after grant → memory transaction still completes and d_read_valid pulses once; no regrant.
- Reset mid-transfer: RESET=1 while in I_RD before mem_read_valid → next cycle busy=0, owner=0, mem_blk_read=0; a late mem_read_valid produces no i_valid.
- Spurious response: mem_write_valid=1 while in I_RD, and mem_read_valid=1 in IDLE → no state change and no output pulse.
